// File: rtl/bit_logic_unit.sv
// bit_logic_unit: registered bitwise ops plus bit-serial shifts/rotates with a start/done handshake.
// Optional macro LOGIC_TRISTATE_EN: out is high-impedance while out_en is low.
module bit_logic_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             out_en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH+3:0] out
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] op_q, op_nx;
  logic [WIDTH-1:0] work, work_nx, logic_res, step_res;
  logic [CW-1:0] cnt, cnt_nx, n;
  logic [WIDTH+3:0] out_q, out_nx;
  logic step_c;
  function automatic logic [WIDTH+3:0] pack(input logic [WIDTH-1:0] r, input logic c);
    return {r[WIDTH-1], r == '0, c, 1'b0, r};
  endfunction
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign n = in2[CW-1:0];
  assign logic_res = op[1] ? (op[0] ? ~in1 : in1 ^ in2) : (op[0] ? in1 | in2 : in1 & in2);
  // op bit 0 selects right vs left, bit 1 feeds the outgoing bit back in for rotates
  assign step_res = op_q[0] ? {op_q[1] & work[0], work[WIDTH-1:1]}
                            : {work[WIDTH-2:0], op_q[1] & work[WIDTH-1]};
  assign step_c = op_q[0] ? work[0] : work[WIDTH-1];
  always_comb begin
    state_nx = state;
    op_nx = op_q;
    work_nx = work;
    cnt_nx = cnt;
    out_nx = out_q;
    case (state)
      IDLE: if (start) begin
        op_nx = op;
        work_nx = in1;
        cnt_nx = n;
        state_nx = (op[2] && n != '0) ? SHIFT : DONE;
        out_nx = !op[2] ? pack(logic_res, 1'b0) : (n == '0 ? pack(in1, 1'b0) : out_q);
      end
      SHIFT: begin
        work_nx = step_res;
        cnt_nx = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          out_nx = pack(step_res, step_c);
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
      op_q <= '0;
      work <= '0;
      cnt <= '0;
      out_q <= '0;
    end else begin
      state <= state_nx;
      op_q <= op_nx;
      work <= work_nx;
      cnt <= cnt_nx;
      out_q <= out_nx;
    end
  end
`ifdef LOGIC_TRISTATE_EN
  assign out = out_en ? out_q : {(WIDTH+4){1'bz}};
`else
  logic unused_out_en;
  assign unused_out_en = out_en;
  assign out = out_q;
`endif
endmodule

// File: tb/tb_bit_logic_unit.sv
// tb_bit_logic_unit: directed and random checks of bit_logic_unit against a closed-form model.
module tb_bit_logic_unit;
  localparam int W = 32;
  logic clock, clear, start, out_en, busy, done;
  logic [2:0] op;
  logic [W-1:0] in1, in2;
  logic [W+3:0] out;
  int checks = 0, failures = 0;
  bit saw_done;
  bit_logic_unit #(.WIDTH(W)) dut (
    .clock(clock), .clear(clear), .start(start), .op(op), .in1(in1), .in2(in2),
    .out_en(out_en), .busy(busy), .done(done), .out(out)
  );
  initial clock = 0;
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [W+3:0] model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    logic [W-1:0] r;
    logic c;
    n = int'(b % W);
    c = 1'b0;
    case (o)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~a;
      3'd4: begin r = a << n; if (n != 0) c = a[W-n]; end
      3'd5: begin r = a >> n; if (n != 0) c = a[n-1]; end
      3'd6: begin r = (n == 0) ? a : (a << n) | (a >> (W - n)); if (n != 0) c = r[0]; end
      default: begin r = (n == 0) ? a : (a >> n) | (a << (W - n)); if (n != 0) c = r[W-1]; end
    endcase
    return {r[W-1], r == '0, c, 1'b0, r};
  endfunction
  task automatic run(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit noise);
    logic [W+3:0] e;
    int n, exp_lat, lat;
    e = model(o, a, b);
    n = int'(b % W);
    exp_lat = (o < 4 || n == 0) ? 1 : n + 1;
    lat = 0;
    @(negedge clock);
    op = o; in1 = a; in2 = b; start = 1;
    @(posedge clock);
    #1 start = 0;
    if (noise) begin op = 3'($urandom); in1 = $urandom; in2 = $urandom; end
    do begin
      @(negedge clock);
      lat++;
      if (!done) begin
        chk("busy_during", 64'(busy), 64'd1);
        if (noise) start = 1'($urandom_range(0, 1));
      end
    end while (!done && lat < 100);
    start = 0;
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("out", 64'(out), 64'(e));
    chk("busy_at_done", 64'(busy), 64'd1);
    @(negedge clock);
    chk("done_pulse", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("out_hold", 64'(out), 64'(e));
  endtask
  initial begin
    clear = 0; start = 0; op = 0; in1 = 0; in2 = 0; out_en = 1;
    repeat (2) @(negedge clock);
    chk("reset_out", 64'(out), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    clear = 1;
    run(3'd2, 32'hF0F0F0F0, 32'hFFFF0000, 0);
    chk("xor_literal", 64'(out), 64'h0_0F0FF0F0);
    run(3'd0, 32'hAAAAAAAA, 32'h55555555, 0);
    chk("and_zero", 64'(out), 64'h4_00000000);
    run(3'd3, 32'h0, 32'h0, 0);
    chk("not_ones", 64'(out), 64'h8_FFFFFFFF);
    run(3'd6, 32'h80000001, 32'd4, 1);
    chk("rol_literal", 64'(out), 64'h0_00000018);
    run(3'd5, 32'h12345678, 32'h0, 1);
    run(3'd4, 32'h3, 32'd31, 1);
    chk("shl_literal", 64'(out), 64'hA_80000000);
    @(negedge clock);
    op = 3'd5; in1 = '1; in2 = 32'd20; start = 1;
    @(posedge clock);
    #1 start = 0;
    repeat (4) @(negedge clock);
    clear = 0;
    #1;
    chk("abort_out", 64'(out), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    repeat (2) @(negedge clock);
    clear = 1;
    saw_done = 0;
    repeat (25) begin @(negedge clock); saw_done |= done | busy; end
    chk("abort_no_done", 64'(saw_done), 64'd0);
    run(3'd1, 32'h1, 32'h2, 0);
    chk("or_literal", 64'(out), 64'h0_00000003);
`ifdef LOGIC_TRISTATE_EN
    run(3'd2, 32'hF0F0F0F0, 32'hFFFF0000, 0);
    out_en = 0;
    #1 chk("tristate_z", 64'(out), 64'({(W+4){1'bz}}));
    out_en = 1;
    #1 chk("tristate_drive", 64'(out), 64'h0_0F0FF0F0);
`endif
    for (int i = 0; i < 40; i++)
      run(3'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 7)), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
